// File: rtl/lsu_ram_port.sv
// Load/store front end for a byte-enabled word RAM with one-cycle read latency.
// Optional build macro LSU_MISALIGNED_SPLIT_EN: misaligned half/word accesses span two words instead of faulting.
module lsu_ram_port #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [2:0]            i_req_funct3,
  input  logic [ADDR_WIDTH:0]   i_req_addr,
  input  logic [DATA_WIDTH:0]   i_req_wdata,
  output logic                  o_resp_valid,
  output logic [DATA_WIDTH:0]   o_resp_rdata,
  output logic                  o_resp_fault,
  output logic                  o_ram_read_enable,
  output logic [ADDR_WIDTH:0]   o_ram_read_addr,
  input  logic [DATA_WIDTH:0]   i_ram_read_data,
  output logic                  o_ram_write_enable,
  output logic [3:0]            o_ram_byte_enable,
  output logic [ADDR_WIDTH:0]   o_ram_write_addr,
  output logic [DATA_WIDTH:0]   o_ram_write_data
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WRITE  = 3'd1;
  localparam logic [2:0] S_READ   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;
`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam logic [2:0] S_WRITE2 = 3'd5;
  localparam logic [2:0] S_READ2  = 3'd6;
`endif

  // Sign/zero extension of the already right-aligned load word.
  function automatic logic [DATA_WIDTH:0] load_extend(input logic [2:0]          f3,
                                                      input logic [DATA_WIDTH:0] w);
    logic [DATA_WIDTH:0] r;
    case (f3)
      3'b000:  r = {{24{w[7]}}, w[7:0]};
      3'b001:  r = {{16{w[15]}}, w[15:0]};
      3'b100:  r = {24'h000000, w[7:0]};
      3'b101:  r = {16'h0000, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  // Next word address; the word index wraps inside its ADDR_WIDTH-1 significant bits.
  function automatic logic [ADDR_WIDTH:0] next_word(input logic [ADDR_WIDTH:0] wa);
    logic [ADDR_WIDTH-2:0] lo;
    lo = wa[ADDR_WIDTH-2:0] + {{(ADDR_WIDTH-2){1'b0}}, 1'b1};
    return {2'b00, lo};
  endfunction

  logic [2:0]          state_q, state_d;
  logic [2:0]          f3_q, f3_d;
  logic [1:0]          off_q, off_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_WIDTH:0] rd_addr_q, rd_addr_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_WIDTH:0] wr_addr_q, wr_addr_d;
  logic [3:0]          be_q, be_d;
  logic [DATA_WIDTH:0] wr_data_q, wr_data_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH:0] resp_rdata_q, resp_rdata_d;
  logic                resp_fault_q, resp_fault_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
  logic                split_q, split_d;
  logic [3:0]          hi_be_q, hi_be_d;
  logic [DATA_WIDTH:0] hi_data_q, hi_data_d;
  logic [DATA_WIDTH:0] lo_word_q, lo_word_d;
  logic                req_split;
  logic [7:0]          win_be;
  logic [2*DATA_WIDTH+1:0] win_data;
  logic [3:0]          sz_mask;
  logic [DATA_WIDTH:0] sz_data;
  logic [2*DATA_WIDTH+1:0] ld_pair;
`endif

  logic [1:0]          req_off;
  logic [ADDR_WIDTH:0] req_waddr;
  logic                req_legal;
  logic                req_misal;
  logic                req_fault;
  logic [3:0]          st_be;
  logic [DATA_WIDTH:0] st_data;
  logic [DATA_WIDTH:0] ld_word;

  assign req_off   = i_req_addr[1:0];
  assign req_waddr = {2'b00, i_req_addr[ADDR_WIDTH:2]};

  always_comb begin
    if (i_req_write) begin
      req_legal = (i_req_funct3 == 3'b000) || (i_req_funct3 == 3'b001) ||
                  (i_req_funct3 == 3'b010);
    end else begin
      req_legal = (i_req_funct3 == 3'b000) || (i_req_funct3 == 3'b001) ||
                  (i_req_funct3 == 3'b010) || (i_req_funct3 == 3'b100) ||
                  (i_req_funct3 == 3'b101);
    end
    case (i_req_funct3[1:0])
      2'b01:   req_misal = req_off[0];
      2'b10:   req_misal = |req_off;
      default: req_misal = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGNED_SPLIT_EN
  assign req_split = req_legal & req_misal;
  assign req_fault = ~req_legal;
`else
  assign req_fault = ~req_legal | req_misal;
`endif

  // Aligned stores replicate the datum across every lane it could occupy.
  always_comb begin
    case (i_req_funct3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << req_off;
        st_data = {4{i_req_wdata[7:0]}};
      end
      2'b01: begin
        st_be   = 4'b0011 << req_off;
        st_data = {2{i_req_wdata[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = i_req_wdata;
      end
    endcase
  end

`ifdef LSU_MISALIGNED_SPLIT_EN
  // Split stores place the datum in a two-word window; low half goes to W, high half to W+1.
  always_comb begin
    case (i_req_funct3[1:0])
      2'b00: begin
        sz_mask = 4'b0001;
        sz_data = {24'h000000, i_req_wdata[7:0]};
      end
      2'b01: begin
        sz_mask = 4'b0011;
        sz_data = {16'h0000, i_req_wdata[15:0]};
      end
      default: begin
        sz_mask = 4'b1111;
        sz_data = i_req_wdata;
      end
    endcase
    win_be   = {4'b0000, sz_mask} << req_off;
    win_data = {{(DATA_WIDTH+1){1'b0}}, sz_data} << {req_off, 3'b000};
  end

  assign ld_pair = {i_ram_read_data, lo_word_q};
  assign ld_word = split_q ? ld_pair[{off_q, 3'b000} +: (DATA_WIDTH+1)]
                           : (i_ram_read_data >> {off_q, 3'b000});
`else
  assign ld_word = i_ram_read_data >> {off_q, 3'b000};
`endif

  always_comb begin
    state_d      = state_q;
    f3_d         = f3_q;
    off_d        = off_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    be_d         = be_q;
    wr_data_d    = wr_data_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_fault_d = resp_fault_q;
`ifdef LSU_MISALIGNED_SPLIT_EN
    split_d      = split_q;
    hi_be_d      = hi_be_q;
    hi_data_d    = hi_data_q;
    lo_word_d    = lo_word_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          f3_d  = i_req_funct3;
          off_d = req_off;
`ifdef LSU_MISALIGNED_SPLIT_EN
          split_d   = req_split;
          hi_be_d   = win_be[7:4];
          hi_data_d = win_data[2*DATA_WIDTH+1:DATA_WIDTH+1];
`endif
          if (req_fault) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
            resp_rdata_d = '0;
          end else if (i_req_write) begin
            state_d   = S_WRITE;
            wr_en_d   = 1'b1;
            wr_addr_d = req_waddr;
`ifdef LSU_MISALIGNED_SPLIT_EN
            be_d      = req_split ? win_be[3:0] : st_be;
            wr_data_d = req_split ? win_data[DATA_WIDTH:0] : st_data;
`else
            be_d      = st_be;
            wr_data_d = st_data;
`endif
          end else begin
            state_d   = S_READ;
            rd_en_d   = 1'b1;
            rd_addr_d = req_waddr;
          end
        end
      end
      S_WRITE: begin
`ifdef LSU_MISALIGNED_SPLIT_EN
        if (split_q) begin
          state_d   = S_WRITE2;
          wr_en_d   = 1'b1;
          wr_addr_d = next_word(wr_addr_q);
          be_d      = hi_be_q;
          wr_data_d = hi_data_q;
        end else begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_fault_d = 1'b0;
          resp_rdata_d = '0;
        end
`else
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_fault_d = 1'b0;
        resp_rdata_d = '0;
`endif
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      S_WRITE2: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_fault_d = 1'b0;
        resp_rdata_d = '0;
      end
`endif
      S_READ: begin
`ifdef LSU_MISALIGNED_SPLIT_EN
        if (split_q) begin
          state_d   = S_READ2;
          rd_en_d   = 1'b1;
          rd_addr_d = next_word(rd_addr_q);
        end else begin
          state_d = S_WAIT;
        end
`else
        state_d = S_WAIT;
`endif
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      // Word W is on the read bus now while W+1 is being fetched.
      S_READ2: begin
        lo_word_d = i_ram_read_data;
        state_d   = S_WAIT;
      end
`endif
      S_WAIT: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_fault_d = 1'b0;
        resp_rdata_d = load_extend(f3_q, ld_word);
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Reset wins over clk_en and abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      f3_q         <= '0;
      off_q        <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      be_q         <= '0;
      wr_data_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      split_q      <= 1'b0;
      hi_be_q      <= '0;
      hi_data_q    <= '0;
      lo_word_q    <= '0;
`endif
    end else if (clk_en) begin
      state_q      <= state_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      be_q         <= be_d;
      wr_data_q    <= wr_data_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
      split_q      <= split_d;
      hi_be_q      <= hi_be_d;
      hi_data_q    <= hi_data_d;
      lo_word_q    <= lo_word_d;
`endif
    end
  end

  assign o_req_ready        = (state_q == S_IDLE) & ~rst;
  assign o_resp_valid       = resp_valid_q;
  assign o_resp_rdata       = resp_rdata_q;
  assign o_resp_fault       = resp_fault_q;
  assign o_ram_read_enable  = rd_en_q;
  assign o_ram_read_addr    = rd_addr_q;
  assign o_ram_write_enable = wr_en_q;
  assign o_ram_byte_enable  = be_q;
  assign o_ram_write_addr   = wr_addr_q;
  assign o_ram_write_data   = wr_data_q;

endmodule

// File: tb/tb_lsu_ram_port.sv
// Bench for lsu_ram_port: word RAM stand-in plus a byte-addressed reference memory model.
// Build with LSU_MISALIGNED_SPLIT_EN defined to exercise the split-access variant.
module tb_lsu_ram_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_write;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_resp_valid;
  logic [31:0] o_resp_rdata;
  logic        o_resp_fault;
  logic        o_ram_read_enable;
  logic [31:0] o_ram_read_addr;
  logic [31:0] i_ram_read_data;
  logic        o_ram_write_enable;
  logic [3:0]  o_ram_byte_enable;
  logic [31:0] o_ram_write_addr;
  logic [31:0] o_ram_write_data;

  always #5 clk = ~clk;

  lsu_ram_port #(.ADDR_WIDTH(31), .DATA_WIDTH(31)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_write(i_req_write), .i_req_funct3(i_req_funct3),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata), .o_resp_fault(o_resp_fault),
    .o_ram_read_enable(o_ram_read_enable), .o_ram_read_addr(o_ram_read_addr),
    .i_ram_read_data(i_ram_read_data),
    .o_ram_write_enable(o_ram_write_enable), .o_ram_byte_enable(o_ram_byte_enable),
    .o_ram_write_addr(o_ram_write_addr), .o_ram_write_data(o_ram_write_data)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word RAM stand-in: byte enables, one-cycle read latency, gated by the shared clk_en.
  logic [31:0] ram [0:255];
  int wr_cnt = 0;
  int rd_cnt = 0;
  always @(posedge clk) begin
    if (clk_en) begin
      if (o_ram_write_enable) begin
        for (int b = 0; b < 4; b++)
          if (o_ram_byte_enable[b]) ram[o_ram_write_addr[7:0]][8*b +: 8] = o_ram_write_data[8*b +: 8];
        wr_cnt++;
      end
      if (o_ram_read_enable) begin
        i_ram_read_data <= ram[o_ram_read_addr[7:0]];
        rd_cnt++;
      end
    end
  end

  // Reference: flat byte memory, transactions applied atomically.
  logic [7:0] ref_mem [0:1023];
  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        fault;
    int          nwr;
    int          nrd;
  } exp_t;
  exp_t exp_q[$];
  int   en_cnt = 0;
  bit   rand_en = 0;

  task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output exp_t e);
    int n;
    bit legal, mis, split, flt;
    logic [31:0] v;
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = w ? (f3 <= 3'd2)
              : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'd0);
`ifdef LSU_MISALIGNED_SPLIT_EN
    flt   = !legal;
    split = legal && mis;
`else
    flt   = !legal || mis;
    split = 1'b0;
`endif
    e.fault = flt;
    e.rdata = '0;
    e.nwr   = 0;
    e.nrd   = 0;
    e.idx   = 0;
    if (!flt && w) begin
      e.idx = 1 + int'(split);
      e.nwr = 1 + int'(split);
      for (int k = 0; k < n; k++) ref_mem[(a + k) & 32'h3FF] = d[8*k +: 8];
    end else if (!flt) begin
      e.idx = 2 + int'(split);
      e.nrd = 1 + int'(split);
      v = '0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[(a + k) & 32'h3FF];
      if (!f3[2]) begin
        if (n == 1) v = {{24{v[7]}}, v[7:0]};
        else if (n == 2) v = {{16{v[15]}}, v[15:0]};
      end
      e.rdata = v;
    end
  endtask

  // Single compare process: every edge, after outputs settle.
  bit          resp_hold  = 0;
  logic [31:0] last_rdata = '0;
  logic        last_fault = 1'b0;
  exp_t        mon_e;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      exp_q.delete();
      resp_hold  = 0;
      last_rdata = '0;
      last_fault = 1'b0;
      wr_cnt     = 0;
      rd_cnt     = 0;
      chk1("rst_resp_valid", o_resp_valid, 1'b0);
      chk1("rst_ram_wen", o_ram_write_enable, 1'b0);
      chk1("rst_ram_ren", o_ram_read_enable, 1'b0);
      chk("rst_resp_rdata", o_resp_rdata, 32'h0);
      chk1("rst_resp_fault", o_resp_fault, 1'b0);
    end else begin
      if (clk_en) begin
        en_cnt++;
        resp_hold = 0;
        if (exp_q.size() > 0 && exp_q[0].idx == en_cnt) begin
          mon_e = exp_q.pop_front();
          resp_hold = 1;
          chk("resp_rdata", o_resp_rdata, mon_e.rdata);
          chk1("resp_fault", o_resp_fault, mon_e.fault);
          chk("ram_writes", wr_cnt, mon_e.nwr);
          chk("ram_reads", rd_cnt, mon_e.nrd);
          wr_cnt     = 0;
          rd_cnt     = 0;
          last_rdata = mon_e.rdata;
          last_fault = mon_e.fault;
        end
      end
      chk1("resp_valid", o_resp_valid, resp_hold);
      chk("rdata_hold", o_resp_rdata, last_rdata);
      chk1("fault_hold", o_resp_fault, last_fault);
      chk1("strobe_excl", o_ram_write_enable && o_ram_read_enable, 1'b0);
    end
  end

  function automatic logic pick_en();
    return rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  task automatic send(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    bit acc;
    int guard;
    acc   = 0;
    guard = 0;
    @(negedge clk);
    i_req_valid  = 1'b1;
    i_req_write  = w;
    i_req_funct3 = f3;
    i_req_addr   = a;
    i_req_wdata  = d;
    while (!acc && guard < 64) begin
      clk_en = pick_en();
      #4;
      acc = o_req_ready && clk_en && !rst;
      if (acc) begin
        model(w, f3, a, d, e);
        e.idx = en_cnt + 1 + e.idx;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #2;
      if (!acc) begin
        guard++;
        @(negedge clk);
      end
    end
    i_req_valid = 1'b0;
    if (!acc) chk1("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 64) begin
      @(negedge clk);
      clk_en = pick_en();
      @(posedge clk);
      #2;
      cyc++;
    end
    if (exp_q.size() != 0) begin
      chk1("resp_timeout", 1'b0, 1'b1);
      exp_q.delete();
    end
  endtask

  task automatic step(input logic en);
    @(negedge clk);
    clk_en = en;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [31:0] v, a, d;
    logic [2:0]  f3;
    logic        w;
    rst = 1'b1; clk_en = 1'b0; i_req_valid = 1'b0; i_req_write = 1'b0;
    i_req_funct3 = '0; i_req_addr = '0; i_req_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      ram[i] = v;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = v[8*b +: 8];
    end
    repeat (3) @(negedge clk);
    chk1("ready_in_reset", o_req_ready, 1'b0);
    rst = 1'b0; clk_en = 1'b1;
    #1;
    chk1("ready_after_reset", o_req_ready, 1'b1);

    // Word store and load at 0x100.
    send(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    chk1("sw_wen", o_ram_write_enable, 1'b1);
    chk1("sw_ren", o_ram_read_enable, 1'b0);
    chk("sw_waddr", o_ram_write_addr, 32'h40);
    chk("sw_be", {28'h0, o_ram_byte_enable}, 32'hF);
    chk("sw_wdata", o_ram_write_data, 32'hDEADBEEF);
    wait_resp(cyc);
    chk("sw_latency", cyc + 1, 2);
    send(1'b0, 3'b010, 32'h100, 32'h0);
    chk1("lw_ren", o_ram_read_enable, 1'b1);
    chk("lw_raddr", o_ram_read_addr, 32'h40);
    wait_resp(cyc);
    chk("lw_latency", cyc + 1, 3);
    chk("lw_rdata", o_resp_rdata, 32'hDEADBEEF);
    chk1("lw_fault", o_resp_fault, 1'b0);

    // Byte lane 3.
    send(1'b1, 3'b000, 32'h103, 32'h000000A5);
    chk("sb_be", {28'h0, o_ram_byte_enable}, 32'h8);
    chk("sb_wdata", o_ram_write_data, 32'hA5A5A5A5);
    wait_resp(cyc);
    send(1'b0, 3'b000, 32'h103, 32'h0);
    wait_resp(cyc);
    chk("lb_rdata", o_resp_rdata, 32'hFFFFFFA5);
    send(1'b0, 3'b100, 32'h103, 32'h0);
    wait_resp(cyc);
    chk("lbu_rdata", o_resp_rdata, 32'h000000A5);

    // Upper halfword.
    send(1'b1, 3'b001, 32'h102, 32'h00008001);
    chk("sh_be", {28'h0, o_ram_byte_enable}, 32'hC);
    chk("sh_wdata", o_ram_write_data, 32'h80018001);
    wait_resp(cyc);
    send(1'b0, 3'b001, 32'h102, 32'h0);
    wait_resp(cyc);
    chk("lh_rdata", o_resp_rdata, 32'hFFFF8001);
    send(1'b0, 3'b101, 32'h102, 32'h0);
    wait_resp(cyc);
    chk("lhu_rdata", o_resp_rdata, 32'h00008001);

`ifdef LSU_MISALIGNED_SPLIT_EN
    send(1'b1, 3'b010, 32'h106, 32'h11223344);
    chk("split_w0_addr", o_ram_write_addr, 32'h41);
    chk("split_w0_be", {28'h0, o_ram_byte_enable}, 32'hC);
    chk("split_w0_data", o_ram_write_data, 32'h33440000);
    step(1'b1);
    chk1("split_w1_wen", o_ram_write_enable, 1'b1);
    chk("split_w1_addr", o_ram_write_addr, 32'h42);
    chk("split_w1_be", {28'h0, o_ram_byte_enable}, 32'h3);
    chk("split_w1_data", o_ram_write_data, 32'h00001122);
    wait_resp(cyc);
    chk("split_sw_latency", cyc + 2, 3);
    send(1'b0, 3'b010, 32'h106, 32'h0);
    wait_resp(cyc);
    chk("split_lw_latency", cyc + 1, 4);
    chk("split_lw_rdata", o_resp_rdata, 32'h11223344);
    chk1("split_lw_fault", o_resp_fault, 1'b0);
`else
    send(1'b0, 3'b010, 32'h101, 32'h0);
    chk1("mis_resp_valid", o_resp_valid, 1'b1);
    chk1("mis_fault", o_resp_fault, 1'b1);
    chk("mis_rdata", o_resp_rdata, 32'h0);
    chk1("mis_ren", o_ram_read_enable, 1'b0);
    chk1("mis_wen", o_ram_write_enable, 1'b0);
    wait_resp(cyc);
    chk("mis_latency", cyc + 1, 1);
`endif
    send(1'b0, 3'b011, 32'h100, 32'h0);
    chk1("illegal_ld_fault", o_resp_fault, 1'b1);
    wait_resp(cyc);
    send(1'b1, 3'b100, 32'h100, 32'h0);
    chk1("illegal_st_fault", o_resp_fault, 1'b1);
    wait_resp(cyc);

    // Clock-enable freeze while the read data is pending.
    send(1'b0, 3'b010, 32'h100, 32'h0);
    step(1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      chk1("freeze_resp_valid", o_resp_valid, 1'b0);
      chk1("freeze_ready", o_req_ready, 1'b0);
      chk1("freeze_ren", o_ram_read_enable, 1'b0);
    end
    wait_resp(cyc);
    chk("freeze_latency", cyc, 1);
    chk("freeze_rdata", o_resp_rdata, 32'h8001BEEF);

    // Reset abandons a load in flight.
    send(1'b0, 3'b010, 32'h100, 32'h0);
    step(1'b1);
    @(negedge clk);
    rst = 1'b1; clk_en = 1'b0;
    @(posedge clk);
    #2;
    chk1("rst_wait_ready", o_req_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0; clk_en = 1'b1;
    #1;
    chk1("rst_release_ready", o_req_ready, 1'b1);
    repeat (4) step(1'b1);
    chk1("rst_no_resp", o_resp_valid, 1'b0);

    // Randomized traffic with random clock-enable gaps.
    rand_en = 1;
    for (int t = 0; t < 200; t++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        if (w) f3 = 3'($urandom_range(0, 2));
        else begin
          case ($urandom_range(0, 4))
            0: f3 = 3'b000;
            1: f3 = 3'b001;
            2: f3 = 3'b010;
            3: f3 = 3'b100;
            default: f3 = 3'b101;
          endcase
        end
      end
      a = 32'h100 + 32'($urandom_range(0, 32'h1F8));
      if ($urandom_range(0, 1) != 0) a[1:0] = 2'b00;
      d = $urandom;
      send(w, f3, a, d);
      wait_resp(cyc);
    end
    rand_en = 0;
    repeat (3) step(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
